// File: rtl/data_mem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, MMIO register
// offsets and the controller FSM states.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    localparam logic [3:0] MMIO_BCD = 4'h0;
    localparam logic [3:0] MMIO_LED = 4'h4;
    localparam logic [3:0] MMIO_CNT = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: merges store data into the addressed byte lanes of
// the current RAM word and extracts/extends sub-word load data.
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_ld_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [3:0]  be;
    logic [31:0] wrep;
    logic [7:0]  b_sel;
    logic [15:0] h_sel;

    assign b_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign h_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        be           = 4'b0000;
        wrep         = wdata_i;
        rdata_o      = 32'h0;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                be      = 4'b0001 << addr_lo_i;
                wrep    = {4{wdata_i[7:0]}};
                rdata_o = unsigned_ld_i ? {24'h0, b_sel} : {{24{b_sel[7]}}, b_sel};
            end
            SZ_HALF: begin
                misaligned_o = addr_lo_i[0];
                be           = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wrep         = {2{wdata_i[15:0]}};
                rdata_o      = unsigned_ld_i ? {16'h0, h_sel} : {{16{h_sel[15]}}, h_sel};
            end
            SZ_WORD: begin
                misaligned_o = (addr_lo_i != 2'b00);
                be           = 4'b1111;
                rdata_o      = rword_i;
            end
            default: misaligned_o = 1'b1;
        endcase
    end

    always_comb begin
        wword_o = rword_i;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) wword_o[8*i +: 8] = wrep[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: sized loads/stores into a word RAM plus an MMIO
// window (BCD, LED, store counter), with optional wait states that stall via ready.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0,
    parameter int BCD_W       = 12,
    parameter int LED_W       = 8
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_ld_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic [BCD_W-1:0]  bcd_o,
    output logic [LED_W-1:0]  led_o,
    output logic [1:0]        state_o
);

    localparam int IDX_W  = ADDR_W - 3;
    localparam int RAM_AW = $clog2(DEPTH_WORDS);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                commit;
    logic                accept;

    logic                cap_we_q, cap_uns_q;
    logic [1:0]          cap_size_q;
    logic [ADDR_W-1:0]   cap_addr_q;
    logic [31:0]         cap_wdata_q;

    logic                cur_we, cur_uns;
    logic [1:0]          cur_size;
    logic [ADDR_W-1:0]   cur_addr;
    logic [31:0]         cur_wdata;

    logic [31:0]         rdata_q;
    logic                err_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [LED_W-1:0]    led_q;
    logic [15:0]         store_cnt_q;

    logic [31:0]         ram [DEPTH_WORDS];
    logic [IDX_W-1:0]    word_idx;
    logic [RAM_AW-1:0]   ram_idx;
    logic                is_mmio, in_range, misaligned, err_c, ram_we;
    logic [31:0]         rword, wword, lane_rdata, mmio_rdata, load_val;

    // Handshake: a request is accepted on any rising edge where req_i && ready_o; its
    // single-cycle rvalid_o pulse follows WAIT_CYCLES+1 cycles later with rdata_o/err_o.
    assign accept   = req_i & ready_o;
    assign ready_o  = (state_q != ST_WAIT);
    assign rvalid_o = (state_q == ST_RESP);
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign bcd_o    = bcd_q;
    assign led_o    = led_q;
    assign state_o  = state_q;

    // In WAIT the captured request is the one being served; otherwise the live inputs.
    always_comb begin
        cur_we    = we_i;
        cur_uns   = unsigned_ld_i;
        cur_size  = size_i;
        cur_addr  = addr_i;
        cur_wdata = wdata_i;
        if (state_q == ST_WAIT) begin
            cur_we    = cap_we_q;
            cur_uns   = cap_uns_q;
            cur_size  = cap_size_q;
            cur_addr  = cap_addr_q;
            cur_wdata = cap_wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        commit  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign is_mmio  = cur_addr[ADDR_W-1];
    assign word_idx = cur_addr[ADDR_W-2:2];
    assign in_range = (32'(word_idx) < DEPTH_WORDS);
    assign ram_idx  = RAM_AW'(word_idx);
    assign rword    = ram[ram_idx];

    mem_lane_align u_align (
        .addr_lo_i     (cur_addr[1:0]),
        .size_i        (cur_size),
        .unsigned_ld_i (cur_uns),
        .wdata_i       (cur_wdata),
        .rword_i       (rword),
        .wword_o       (wword),
        .rdata_o       (lane_rdata),
        .misaligned_o  (misaligned)
    );

    assign err_c = misaligned | (is_mmio ? (cur_size != SZ_WORD) : !in_range);

    always_comb begin
        case (cur_addr[3:0])
            MMIO_BCD: mmio_rdata = 32'(bcd_q);
            MMIO_LED: mmio_rdata = 32'(led_q);
            MMIO_CNT: mmio_rdata = {16'h0, store_cnt_q};
            default:  mmio_rdata = 32'h0;
        endcase
    end

    assign load_val = err_c ? 32'h0 : (is_mmio ? mmio_rdata : lane_rdata);
    // Gated by reset so a request presented while reset is low never lands in RAM.
    assign ram_we   = commit & cur_we & ~err_c & ~is_mmio & reset_ni;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            cap_we_q    <= 1'b0;
            cap_uns_q   <= 1'b0;
            cap_size_q  <= 2'b00;
            cap_addr_q  <= '0;
            cap_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            bcd_q       <= '0;
            led_q       <= '0;
            store_cnt_q <= 16'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                cap_we_q    <= we_i;
                cap_uns_q   <= unsigned_ld_i;
                cap_size_q  <= size_i;
                cap_addr_q  <= addr_i;
                cap_wdata_q <= wdata_i;
            end
            if (commit) begin
                err_q   <= err_c;
                rdata_q <= cur_we ? 32'h0 : load_val;
                if (cur_we && !err_c) begin
                    if (is_mmio) begin
                        if (cur_addr[3:0] == MMIO_BCD) bcd_q <= cur_wdata[BCD_W-1:0];
                        if (cur_addr[3:0] == MMIO_LED) led_q <= cur_wdata[LED_W-1:0];
                    end else begin
                        store_cnt_q <= store_cnt_q + 16'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_we) ram[ram_idx] <= wword;
    end

endmodule
